// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if: data-memory req/ack bus; master drives req/we/addr/be/wdata, slave returns rdata/ack
interface mem_access_stage_if;
  logic mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_be;
  modport master(output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_rdata, mem_ack);
  modport slave(input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_rdata, mem_ack);
endinterface

// File: rtl/mem_access_stage.sv
// mem_access_stage: MIPS load/store stage (CLK/RST; Ins/Addr/ExResult/Wdata in; Result/Stall/BusErr/AdErr out; bus master port), MISALIGN_TRAP_EN traps misaligned accesses
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [31:0]               Ins,
  input  logic [31:0]               Addr,
  input  logic [31:0]               ExResult,
  input  logic [31:0]               Wdata,
  output logic [31:0]               Result,
  output logic                      Stall,
  output logic                      BusErr,
  output logic                      AdErr,
  mem_access_stage_if.master        bus
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state_q;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] buf_q, wdata_d, ld_val;
  logic [3:0] be_d;
  logic [7:0] lb;
  logic [15:0] lh;
  logic [5:0] op;
  logic [1:0] a;
  logic bus_err_q, ad_err_q, is_ld, is_st, mis;
  assign op = Ins[31:26];
  assign a = Addr[1:0];
  assign is_ld = op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  assign is_st = op inside {6'h28, 6'h29, 6'h2B};
`ifdef MISALIGN_TRAP_EN
  assign mis = ((op inside {6'h21, 6'h25, 6'h29}) && a[0]) || ((op inside {6'h23, 6'h2B}) && a != 2'b00);
`else
  assign mis = 1'b0;
`endif
  assign cnt_d = cnt_q + 16'd1;
  assign Stall = state_q == REQ || (state_q == IDLE && (is_ld || is_st));
  assign BusErr = bus_err_q;
  assign AdErr = ad_err_q;
  always_comb begin
    be_d = op == 6'h28 ? 4'b0001 << a : op == 6'h29 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_d = op == 6'h28 ? {4{Wdata[7:0]}} : op == 6'h29 ? {2{Wdata[15:0]}} : Wdata;
    lb = 8'(buf_q >> {a, 3'b000});
    lh = a[1] ? buf_q[31:16] : buf_q[15:0];
    ld_val = op == 6'h20 ? {{24{lb[7]}}, lb} :
             op == 6'h24 ? {24'b0, lb} :
             op == 6'h21 ? {{16{lh[15]}}, lh} :
             op == 6'h25 ? {16'b0, lh} : buf_q;
    Result = is_ld ? ld_val : ExResult;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_be <= '0;
      bus.mem_wdata <= '0;
      bus_err_q <= 1'b0;
      ad_err_q <= 1'b0;
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      bus_err_q <= 1'b0;
      ad_err_q <= 1'b0;
      case (state_q)
        IDLE: if (is_ld || is_st) begin
          if (mis) begin
            state_q <= DONE;
            ad_err_q <= 1'b1;
            buf_q <= '0;
          end else begin
            state_q <= REQ;
            bus.mem_req <= 1'b1;
            bus.mem_we <= is_st;
            bus.mem_addr <= {Addr[31:2], 2'b00};
            bus.mem_be <= be_d;
            bus.mem_wdata <= wdata_d;
            cnt_q <= '0;
          end
        end
        REQ: if (bus.mem_ack) begin
          buf_q <= bus.mem_rdata;
          bus.mem_req <= 1'b0;
          state_q <= DONE;
        end else if ({16'b0, cnt_d} == TIMEOUT_CYCLES) begin
          buf_q <= '0;
          bus.mem_req <= 1'b0;
          bus_err_q <= 1'b1;
          state_q <= DONE;
        end else cnt_q <= cnt_d;
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
